rv32_decode: RTL and testbench

RV32_DECODE -- requirements
Module: rv32_decode

---
 rtl/rv32_decode.sv | 202 ++++++++++++++++++++
 tb/tb_rv32_decode.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_decode.sv
`default_nettype none
// ============================================================================
// Module      : rv32_decode
// Description : RV32I decode stage. Decode slot register, immediate and control
//               decode, ex/mem/wb operand bypass, load-use hazard detection.
// Revision    : 1.0
// ============================================================================
module rv32_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        stall_in,
  input  logic        flush_in,
  output logic        stall_out,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  input  logic [31:0] rs1_value_in,
  input  logic [31:0] rs2_value_in,
  input  logic [4:0]  ex_rd_in,
  input  logic        ex_rd_write_in,
  input  logic [31:0] ex_value_in,
  input  logic [4:0]  mem_rd_in,
  input  logic        mem_rd_write_in,
  input  logic [31:0] mem_value_in,
  input  logic [4:0]  wb_rd_in,
  input  logic        wb_rd_write_in,
  input  logic [31:0] wb_value_in,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_out,
  output logic        mem_read_out,
  output logic [31:0] rs1_value_out,
  output logic [31:0] rs2_value_out,
  output logic [31:0] imm_out
);

  localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] C_OPC_OP     = 7'b0110011;

  logic        r_d_valid;
  logic [31:0] r_d_pc;
  logic [31:0] r_d_instr;

  logic        r_valid_out;
  logic [31:0] r_pc_out;
  logic [31:0] r_instr_out;
  logic [4:0]  r_rd_out;
  logic        r_rd_write_out;
  logic        r_mem_read_out;
  logic [31:0] r_rs1_value_out;
  logic [31:0] r_rs2_value_out;
  logic [31:0] r_imm_out;

  logic [6:0]  w_opc;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [31:0] w_imm;
  logic        w_uses_rs1;
  logic        w_uses_rs2;
  logic        w_writes;
  logic        w_mem_read;
  logic        w_rd_write;
  logic [31:0] w_rs1_fwd;
  logic [31:0] w_rs2_fwd;
  logic        w_hazard;

  assign w_opc = r_d_instr[6:0];
  assign w_rd  = r_d_instr[11:7];
  assign w_rs1 = r_d_instr[19:15];
  assign w_rs2 = r_d_instr[24:20];

  assign rs1_out = instr_in[19:15];
  assign rs2_out = instr_in[24:20];

  always_comb begin
    w_imm      = 32'd0;
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    w_writes   = 1'b0;
    w_mem_read = 1'b0;
    case (w_opc)
      C_OPC_LOAD, C_OPC_OPIMM, C_OPC_JALR: begin
        w_imm      = {{20{r_d_instr[31]}}, r_d_instr[31:20]};
        w_uses_rs1 = 1'b1;
        w_writes   = 1'b1;
        w_mem_read = (w_opc == C_OPC_LOAD);
      end
      C_OPC_STORE: begin
        w_imm      = {{20{r_d_instr[31]}}, r_d_instr[31:25], r_d_instr[11:7]};
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      C_OPC_BRANCH: begin
        w_imm      = {{19{r_d_instr[31]}}, r_d_instr[31], r_d_instr[7],
                      r_d_instr[30:25], r_d_instr[11:8], 1'b0};
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      C_OPC_LUI, C_OPC_AUIPC: begin
        w_imm    = {r_d_instr[31:12], 12'd0};
        w_writes = 1'b1;
      end
      C_OPC_JAL: begin
        w_imm    = {{11{r_d_instr[31]}}, r_d_instr[31], r_d_instr[19:12],
                    r_d_instr[20], r_d_instr[30:21], 1'b0};
        w_writes = 1'b1;
      end
      C_OPC_OP: begin
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
        w_writes   = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_rd_write = w_writes & (w_rd != 5'd0);

  // Youngest producer wins; x0 is never bypassed.
  function automatic logic [31:0] f_fwd(input logic [4:0] src, input logic [31:0] rf_val);
    logic [31:0] v;
    v = rf_val;
    if (src != 5'd0) begin
      if (ex_rd_write_in && ex_rd_in == src)
        v = ex_value_in;
      else if (mem_rd_write_in && mem_rd_in == src)
        v = mem_value_in;
      else if (wb_rd_write_in && wb_rd_in == src)
        v = wb_value_in;
    end
    return v;
  endfunction

  assign w_rs1_fwd = f_fwd(w_rs1, rs1_value_in);
  assign w_rs2_fwd = f_fwd(w_rs2, rs2_value_in);

  assign w_hazard = (w_uses_rs1 && r_rd_out == w_rs1) || (w_uses_rs2 && r_rd_out == w_rs2);

  assign stall_out = r_d_valid & r_valid_out & r_mem_read_out & r_rd_write_out &
                     (r_rd_out != 5'd0) & w_hazard;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d_valid       <= 1'b0;
      r_d_pc          <= 32'd0;
      r_d_instr       <= 32'd0;
      r_valid_out     <= 1'b0;
      r_pc_out        <= 32'd0;
      r_instr_out     <= 32'd0;
      r_rd_out        <= 5'd0;
      r_rd_write_out  <= 1'b0;
      r_mem_read_out  <= 1'b0;
      r_rs1_value_out <= 32'd0;
      r_rs2_value_out <= 32'd0;
      r_imm_out       <= 32'd0;
    end else if (flush_in) begin
      r_d_valid   <= 1'b0;
      r_valid_out <= 1'b0;
    end else if (stall_in) begin
      r_d_valid <= r_d_valid;
    end else if (stall_out) begin
      r_valid_out <= 1'b0;
    end else begin
      r_d_valid       <= valid_in;
      r_d_pc          <= pc_in;
      r_d_instr       <= instr_in;
      r_valid_out     <= r_d_valid;
      r_pc_out        <= r_d_pc;
      r_instr_out     <= r_d_instr;
      r_rd_out        <= w_rd;
      r_rd_write_out  <= r_d_valid & w_rd_write;
      r_mem_read_out  <= r_d_valid & w_mem_read;
      r_rs1_value_out <= w_rs1_fwd;
      r_rs2_value_out <= w_rs2_fwd;
      r_imm_out       <= w_imm;
    end
  end

  assign valid_out     = r_valid_out;
  assign pc_out        = r_pc_out;
  assign instr_out     = r_instr_out;
  assign rd_out        = r_rd_out;
  assign rd_write_out  = r_rd_write_out;
  assign mem_read_out  = r_mem_read_out;
  assign rs1_value_out = r_rs1_value_out;
  assign rs2_value_out = r_rs2_value_out;
  assign imm_out       = r_imm_out;

endmodule
`default_nettype wire

// File: tb/tb_rv32_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32_decode
// Description : Directed and random checks of rv32_decode against an
//               instruction-level reference model.
// Revision    : 1.0
// ============================================================================
module tb_rv32_decode;

  logic        clk = 1'b0;
  logic        reset, valid_in, stall_in, flush_in;
  logic [31:0] pc_in, instr_in, rs1_value_in, rs2_value_in;
  logic [4:0]  ex_rd_in, mem_rd_in, wb_rd_in;
  logic        ex_rd_write_in, mem_rd_write_in, wb_rd_write_in;
  logic [31:0] ex_value_in, mem_value_in, wb_value_in;
  logic        stall_out, valid_out, rd_write_out, mem_read_out;
  logic [4:0]  rs1_out, rs2_out, rd_out;
  logic [31:0] pc_out, instr_out, rs1_value_out, rs2_value_out, imm_out;

  int total = 0;
  int bad   = 0;

  // Reference state: decode slot and execute-side outputs.
  bit          m_dv, m_vo, m_rdw, m_mr;
  logic [31:0] m_dpc, m_di, m_pc, m_ins, m_r1, m_r2, m_imm;
  logic [4:0]  m_rd;

  rv32_decode dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pc_in(pc_in), .instr_in(instr_in),
    .stall_in(stall_in), .flush_in(flush_in), .stall_out(stall_out),
    .rs1_out(rs1_out), .rs2_out(rs2_out),
    .rs1_value_in(rs1_value_in), .rs2_value_in(rs2_value_in),
    .ex_rd_in(ex_rd_in), .ex_rd_write_in(ex_rd_write_in), .ex_value_in(ex_value_in),
    .mem_rd_in(mem_rd_in), .mem_rd_write_in(mem_rd_write_in), .mem_value_in(mem_value_in),
    .wb_rd_in(wb_rd_in), .wb_rd_write_in(wb_rd_write_in), .wb_value_in(wb_value_in),
    .valid_out(valid_out), .pc_out(pc_out), .instr_out(instr_out), .rd_out(rd_out),
    .rd_write_out(rd_write_out), .mem_read_out(mem_read_out),
    .rs1_value_out(rs1_value_out), .rs2_value_out(rs2_value_out), .imm_out(imm_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int sext(input int raw, input int n);
    return (raw >= (1 << (n - 1))) ? raw - (1 << n) : raw;
  endfunction

  // Instruction semantics from the opcode table, independent of any datapath.
  function automatic void mdec(input logic [31:0] ins, output logic [31:0] imm,
                               output bit u1, output bit u2, output bit wr, output bit mr);
    int raw;
    byte fmt;
    fmt = "N"; u1 = 0; u2 = 0; wr = 0; mr = 0;
    case (ins[6:0])
      7'b0000011: begin fmt = "I"; u1 = 1; wr = 1; mr = 1; end
      7'b0010011, 7'b1100111: begin fmt = "I"; u1 = 1; wr = 1; end
      7'b0100011: begin fmt = "S"; u1 = 1; u2 = 1; end
      7'b1100011: begin fmt = "B"; u1 = 1; u2 = 1; end
      7'b0110111, 7'b0010111: begin fmt = "U"; wr = 1; end
      7'b1101111: begin fmt = "J"; wr = 1; end
      7'b0110011: begin fmt = "R"; u1 = 1; u2 = 1; wr = 1; end
      default: ;
    endcase
    case (fmt)
      "I": imm = sext(int'(ins >> 20), 12);
      "S": imm = sext(int'(((ins >> 25) << 5) | ((ins >> 7) & 31)), 12);
      "B": begin
        raw = int'((((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11) |
                   (((ins >> 25) & 63) << 5) | (((ins >> 8) & 15) << 1));
        imm = sext(raw, 13);
      end
      "U": imm = ins & 32'hFFFFF000;
      "J": begin
        raw = int'((((ins >> 31) & 1) << 20) | (((ins >> 12) & 255) << 12) |
                   (((ins >> 20) & 1) << 11) | (((ins >> 21) & 1023) << 1));
        imm = sext(raw, 21);
      end
      default: imm = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] mfwd(input logic [4:0] f, input logic [31:0] rf);
    logic [4:0]  rds [3];
    bit          wrs [3];
    logic [31:0] vals[3];
    rds  = '{ex_rd_in, mem_rd_in, wb_rd_in};
    wrs  = '{ex_rd_write_in, mem_rd_write_in, wb_rd_write_in};
    vals = '{ex_value_in, mem_value_in, wb_value_in};
    if (f == 0) return rf;
    for (int k = 0; k < 3; k++)
      if (wrs[k] && rds[k] == f) return vals[k];
    return rf;
  endfunction

  function automatic bit mstall();
    logic [31:0] imm;
    bit u1, u2, wr, mr;
    mdec(m_di, imm, u1, u2, wr, mr);
    return m_dv && m_vo && m_mr && m_rdw && m_rd != 0 &&
           ((u1 && m_rd == m_di[19:15]) || (u2 && m_rd == m_di[24:20]));
  endfunction

  task automatic mupdate(input bit st);
    logic [31:0] imm;
    bit u1, u2, wr, mr;
    if (reset) begin
      m_dv = 0; m_dpc = 0; m_di = 0; m_vo = 0; m_pc = 0; m_ins = 0;
      m_rd = 0; m_rdw = 0; m_mr = 0; m_r1 = 0; m_r2 = 0; m_imm = 0;
    end else if (flush_in) begin
      m_dv = 0; m_vo = 0;
    end else if (stall_in) begin
      m_vo = m_vo;
    end else if (st) begin
      m_vo = 0;
    end else begin
      mdec(m_di, imm, u1, u2, wr, mr);
      m_vo  = m_dv;
      m_pc  = m_dpc;
      m_ins = m_di;
      m_rd  = m_di[11:7];
      m_rdw = m_dv && wr && m_di[11:7] != 0;
      m_mr  = m_dv && mr;
      m_r1  = mfwd(m_di[19:15], rs1_value_in);
      m_r2  = mfwd(m_di[24:20], rs2_value_in);
      m_imm = imm;
      m_dv  = valid_in;
      m_dpc = pc_in;
      m_di  = instr_in;
    end
  endtask

  // One clock: combinational checks before the edge, registered checks after.
  task automatic step();
    bit st;
    #1;
    st = mstall();
    chk("stall_out", 32'(stall_out), 32'(st));
    chk("rs1_out", 32'(rs1_out), 32'(instr_in[19:15]));
    chk("rs2_out", 32'(rs2_out), 32'(instr_in[24:20]));
    @(posedge clk);
    mupdate(st);
    #1;
    chk("valid_out", 32'(valid_out), 32'(m_vo));
    chk("pc_out", pc_out, m_pc);
    chk("instr_out", instr_out, m_ins);
    chk("rd_out", 32'(rd_out), 32'(m_rd));
    chk("rd_write_out", 32'(rd_write_out), 32'(m_rdw));
    chk("mem_read_out", 32'(mem_read_out), 32'(m_mr));
    chk("rs1_value_out", rs1_value_out, m_r1);
    chk("rs2_value_out", rs2_value_out, m_r2);
    chk("imm_out", imm_out, m_imm);
  endtask

  task automatic idle();
    reset = 0; valid_in = 0; stall_in = 0; flush_in = 0; pc_in = 0; instr_in = 0;
    rs1_value_in = 0; rs2_value_in = 0;
    ex_rd_in = 0; ex_rd_write_in = 0; ex_value_in = 0;
    mem_rd_in = 0; mem_rd_write_in = 0; mem_value_in = 0;
    wb_rd_in = 0; wb_rd_write_in = 0; wb_value_in = 0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] ins);
    valid_in = 1; pc_in = pc; instr_in = ins;
  endtask

  logic [6:0] opcs [10] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
                            7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b1111111};

  initial begin
    idle();
    m_dv = 0; m_vo = 0; m_rdw = 0; m_mr = 0; m_dpc = 0; m_di = 0; m_pc = 0;
    m_ins = 0; m_r1 = 0; m_r2 = 0; m_imm = 0; m_rd = 0;

    // Reset state
    reset = 1; step(); step(); reset = 0;
    chk("reset_valid_out", 32'(valid_out), 32'd0);
    chk("reset_imm_out", imm_out, 32'd0);

    // addi x1,x0,-5
    fetch(32'h100, 32'hFFB00093); step();
    valid_in = 0; step();
    chk("addi_imm", imm_out, 32'hFFFFFFFB);
    chk("addi_rd", 32'(rd_out), 32'd1);
    chk("addi_rdw", 32'(rd_write_out), 32'd1);
    chk("addi_valid", 32'(valid_out), 32'd1);

    // add x3,x1,x2 with ex/mem both targeting x1
    fetch(32'h104, 32'h002081B3); step();
    valid_in = 0;
    ex_rd_in = 1; ex_rd_write_in = 1; ex_value_in = 32'hA;
    mem_rd_in = 1; mem_rd_write_in = 1; mem_value_in = 32'hB;
    wb_rd_in = 2; wb_rd_write_in = 1; wb_value_in = 32'hC;
    step();
    chk("fwd_rs1", rs1_value_out, 32'hA);
    chk("fwd_rs2", rs2_value_out, 32'hC);
    idle();

    // x0 never forwarded
    fetch(32'h108, 32'h00500393); step();
    valid_in = 0; ex_rd_in = 0; ex_rd_write_in = 1; ex_value_in = 32'hDEAD;
    step();
    chk("x0_rs1", rs1_value_out, 32'd0);
    idle();

    // Load-use: lw x5,0(x0); add x6,x5,x5
    fetch(32'h10C, 32'h00002283); step();
    fetch(32'h110, 32'h00528333); step();
    valid_in = 0; instr_in = 0;
    #1 chk("lu_stall_on", 32'(stall_out), 32'd1);
    step();
    chk("lu_bubble", 32'(valid_out), 32'd0);
    chk("lu_stall_off", 32'(stall_out), 32'd0);
    step();
    chk("lu_issue_valid", 32'(valid_out), 32'd1);
    chk("lu_issue_pc", pc_out, 32'h110);

    // flush together with stall
    fetch(32'h114, 32'h00500393); step();
    valid_in = 0; stall_in = 1; flush_in = 1; step();
    chk("flush_valid", 32'(valid_out), 32'd0);
    stall_in = 0; flush_in = 0; step();
    chk("flush_dvalid", 32'(valid_out), 32'd0);

    // Reset during a load-use stall
    fetch(32'h118, 32'h00002283); step();
    fetch(32'h11C, 32'h00528333); step();
    valid_in = 0;
    #1 chk("rst_pre_stall", 32'(stall_out), 32'd1);
    reset = 1; step(); reset = 0;
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd0);
    fetch(32'h200, 32'hFFB00093); step();
    valid_in = 0; step();
    chk("rst_next_valid", 32'(valid_out), 32'd1);
    chk("rst_next_imm", imm_out, 32'hFFFFFFFB);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[6:0]   = opcs[$urandom_range(0, 9)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      reset    = ($urandom_range(0, 99) < 2);
      flush_in = ($urandom_range(0, 99) < 5);
      stall_in = ($urandom_range(0, 99) < 10);
      valid_in = ($urandom_range(0, 99) < 80);
      pc_in    = $urandom;
      instr_in = ins;
      rs1_value_in = (m_di[19:15] == 0) ? 32'd0 : $urandom;
      rs2_value_in = (m_di[24:20] == 0) ? 32'd0 : $urandom;
      ex_rd_in  = 5'($urandom_range(0, 7)); ex_rd_write_in  = 1'($urandom); ex_value_in  = $urandom;
      mem_rd_in = 5'($urandom_range(0, 7)); mem_rd_write_in = 1'($urandom); mem_value_in = $urandom;
      wb_rd_in  = 5'($urandom_range(0, 7)); wb_rd_write_in  = 1'($urandom); wb_value_in  = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
